// File: rtl/hazard_ctrl.sv
// hazard_ctrl: tracks destination registers in flight for the five-stage RV32I
// core, selects execute-stage operand forwarding, and raises load-use stalls,
// redirect flushes and the ECALL drain/halt sequence.
module hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst_d,
  input  logic        valid_d,
  input  logic        redirect,
  output logic        stall_fd,
  output logic        bubble_x,
  output logic        flush_fd,
  output logic [1:0]  fwd_rs1_sel,
  output logic [1:0]  fwd_rs2_sel,
  output logic        capture_wb,
  output logic        halted
);

  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BCC  = 7'b1100011;
  localparam logic [6:0] OP_LCC  = 7'b0000011;
  localparam logic [6:0] OP_SCC  = 7'b0100011;
  localparam logic [6:0] OP_MCC  = 7'b0010011;
  localparam logic [6:0] OP_RCC  = 7'b0110011;
  localparam logic [6:0] OP_FCC  = 7'b0001111;
  localparam logic [6:0] OP_CCC  = 7'b1110011;

  // The execute slot keeps the full decode; downstream slots only need what
  // forwarding and drain detection consume (source fields are dead past X).
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wen;
    logic       is_load;
    logic       is_ecall;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
  } xslot_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wen;
  } pslot_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } state_t;

  xslot_t x_q, x_d, dec;
  pslot_t m_q, m_d, w_q, w_d, r_q, r_d;
  state_t state_q, state_d;
  logic   halted_q, halted_d;
  logic   lu;
  logic   x_ecall;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic use_rs,
                                         input pslot_t m, input pslot_t w,
                                         input pslot_t r);
    logic [1:0] sel;
    sel = 2'b00;
    if (use_rs && (rs != 5'd0)) begin
      if (m.valid && m.wen && (m.rd == rs))      sel = 2'b01;
      else if (w.valid && w.wen && (w.rd == rs)) sel = 2'b10;
      else if (r.valid && r.wen && (r.rd == rs)) sel = 2'b11;
    end
    return sel;
  endfunction

  // Decode the instruction waiting in decode into slot form.
  always_comb begin
    logic [6:0] op;
    op           = inst_d[6:0];
    dec          = '0;
    dec.valid    = 1'b1;
    dec.rd       = inst_d[11:7];
    dec.rs1      = inst_d[19:15];
    dec.rs2      = inst_d[24:20];
    dec.wen      = !((op == OP_BCC) || (op == OP_SCC) || (op == OP_FCC) ||
                     (op == OP_CCC)) && (inst_d[11:7] != 5'd0);
    dec.use1     = (op == OP_JALR) || (op == OP_BCC) || (op == OP_LCC) ||
                   (op == OP_SCC) || (op == OP_MCC) || (op == OP_RCC);
    dec.use2     = (op == OP_BCC) || (op == OP_SCC) || (op == OP_RCC);
    dec.is_load  = (op == OP_LCC);
    dec.is_ecall = (op == OP_CCC) && (inst_d[31:7] == 25'd0);
  end

  // Hazard outputs, forwarding selects and next slot contents.
  always_comb begin
    x_ecall = (state_q == RUN) && x_q.valid && x_q.is_ecall;
    lu = x_q.valid && x_q.is_load && x_q.wen && valid_d &&
         ((dec.use1 && (dec.rs1 != 5'd0) && (dec.rs1 == x_q.rd)) ||
          (dec.use2 && (dec.rs2 != 5'd0) && (dec.rs2 == x_q.rd)));

    // While ECALL sits in X the decode instruction is younger and must not
    // enter; holding it here keeps the drain at exactly three cycles. Redirect
    // is ignored in that cycle and whenever the core is not running.
    flush_fd = (state_q == RUN) && !x_ecall && redirect;
    bubble_x = (state_q != RUN) || x_ecall || redirect || lu;
    stall_fd = (state_q != RUN) || x_ecall || (lu && !redirect);

    fwd_rs1_sel = fwd_sel(x_q.rs1, x_q.valid && x_q.use1, m_q, w_q, r_q);
    fwd_rs2_sel = fwd_sel(x_q.rs2, x_q.valid && x_q.use2, m_q, w_q, r_q);
    capture_wb  = w_q.valid && w_q.wen;

    x_d = (valid_d && !bubble_x) ? dec : '0;
    m_d = '{valid: x_q.valid, rd: x_q.rd, wen: x_q.wen};
    w_d = m_q;
    r_d = w_q;
  end

  // Halt sequencing: X is always empty in DRAIN, so once M and W are empty the
  // coming edge leaves M, W and R all invalid.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (x_q.valid && x_q.is_ecall) state_d = DRAIN;
      DRAIN:   if (!m_q.valid && !w_q.valid) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
    halted_d = (state_d == HALTED);
  end

  assign halted = halted_q;

  // Slot pipeline and halt state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q      <= '0;
      m_q      <= '0;
      w_q      <= '0;
      r_q      <= '0;
      state_q  <= RUN;
      halted_q <= 1'b0;
    end else begin
      x_q      <= x_d;
      m_q      <= m_d;
      w_q      <= w_d;
      r_q      <= r_d;
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors for hazard_ctrl with hand-computed expectations.
module tb_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] inst_d;
  logic        valid_d;
  logic        redirect;
  logic        stall_fd;
  logic        bubble_x;
  logic        flush_fd;
  logic [1:0]  fwd_rs1_sel;
  logic [1:0]  fwd_rs2_sel;
  logic        capture_wb;
  logic        halted;

  int unsigned n_checks;
  int unsigned n_errors;

  hazard_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .inst_d      (inst_d),
    .valid_d     (valid_d),
    .redirect    (redirect),
    .stall_fd    (stall_fd),
    .bubble_x    (bubble_x),
    .flush_fd    (flush_fd),
    .fwd_rs1_sel (fwd_rs1_sel),
    .fwd_rs2_sel (fwd_rs2_sel),
    .capture_wb  (capture_wb),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] add(input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd0, rs1, 3'b010, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1);
    return {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100011};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle and present decode-stage inputs for the new cycle.
  task automatic drive(input logic [31:0] i, input logic v, input logic r);
    @(posedge clk);
    #1;
    inst_d   = i;
    valid_d  = v;
    redirect = r;
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) drive(NOP, 1'b0, 1'b0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_stall"},  stall_fd,    0);
    check({tag, "_bubble"}, bubble_x,    0);
    check({tag, "_flush"},  flush_fd,    0);
    check({tag, "_fwd1"},   fwd_rs1_sel, 0);
    check({tag, "_fwd2"},   fwd_rs2_sel, 0);
    check({tag, "_cap"},    capture_wb,  0);
    check({tag, "_halt"},   halted,      0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    inst_d   = '0;
    valid_d  = 1'b0;
    redirect = 1'b0;
    idle(2);
    check_quiet("reset");
    reset = 1'b0;

    // Back-to-back dependency: ADDI x5 in M while ADD x6,x5,x5 in X.
    drive(addi(5'd5, 5'd0, 12'd7), 1'b1, 1'b0);
    drive(add(5'd6, 5'd5, 5'd5), 1'b1, 1'b0);
    drive(NOP, 1'b0, 1'b0);
    check("b2b_fwd1", fwd_rs1_sel, 2'b01);
    check("b2b_fwd2", fwd_rs2_sel, 2'b01);
    check("b2b_stall", stall_fd, 0);
    idle(4);

    // One NOP between producer and consumer: forward from W.
    drive(addi(5'd5, 5'd0, 12'd7), 1'b1, 1'b0);
    drive(NOP, 1'b1, 1'b0);
    drive(add(5'd6, 5'd5, 5'd0), 1'b1, 1'b0);
    drive(NOP, 1'b0, 1'b0);
    check("gap1_fwd1", fwd_rs1_sel, 2'b10);
    check("gap1_fwd2", fwd_rs2_sel, 2'b00);
    idle(4);

    // Two NOPs: capture the writeback, then forward from the holding register.
    drive(addi(5'd5, 5'd0, 12'd7), 1'b1, 1'b0);
    drive(NOP, 1'b1, 1'b0);
    drive(NOP, 1'b1, 1'b0);
    drive(add(5'd6, 5'd5, 5'd0), 1'b1, 1'b0);
    check("gap2_cap", capture_wb, 1);
    drive(NOP, 1'b0, 1'b0);
    check("gap2_fwd1", fwd_rs1_sel, 2'b11);
    check("gap2_cap_nop", capture_wb, 0);
    idle(4);

    // Load-use: one-cycle stall, then the consumer forwards from W.
    drive(lw(5'd7, 5'd2), 1'b1, 1'b0);
    drive(add(5'd8, 5'd7, 5'd1), 1'b1, 1'b0);
    check("lu_stall", stall_fd, 1);
    check("lu_bubble", bubble_x, 1);
    check("lu_flush", flush_fd, 0);
    drive(add(5'd8, 5'd7, 5'd1), 1'b1, 1'b0);
    check("lu_stall_end", stall_fd, 0);
    check("lu_bubble_end", bubble_x, 0);
    drive(NOP, 1'b0, 1'b0);
    check("lu_fwd1", fwd_rs1_sel, 2'b10);
    check("lu_fwd2", fwd_rs2_sel, 2'b00);
    idle(4);

    // x0 is never forwarded.
    drive(addi(5'd0, 5'd0, 12'd1), 1'b1, 1'b0);
    drive(add(5'd9, 5'd0, 5'd0), 1'b1, 1'b0);
    drive(NOP, 1'b0, 1'b0);
    check("x0_fwd1", fwd_rs1_sel, 2'b00);
    check("x0_fwd2", fwd_rs2_sel, 2'b00);
    idle(4);

    // Store data forwards through rs2.
    drive(addi(5'd5, 5'd0, 12'd3), 1'b1, 1'b0);
    drive(sw(5'd5, 5'd2), 1'b1, 1'b0);
    drive(NOP, 1'b0, 1'b0);
    check("sw_fwd2", fwd_rs2_sel, 2'b01);
    check("sw_fwd1", fwd_rs1_sel, 2'b00);
    idle(4);

    // Redirect overrides a load-use in the same cycle.
    drive(lw(5'd7, 5'd2), 1'b1, 1'b0);
    drive(add(5'd8, 5'd7, 5'd1), 1'b1, 1'b1);
    check("redir_flush", flush_fd, 1);
    check("redir_bubble", bubble_x, 1);
    check("redir_stall", stall_fd, 0);
    idle(4);

    // ECALL in X, three DRAIN cycles, then HALTED held.
    drive(ECALL, 1'b1, 1'b0);
    drive(NOP, 1'b1, 1'b0);
    check("ecall_x_stall", stall_fd, 1);
    check("ecall_x_halt", halted, 0);
    for (int unsigned c = 1; c <= 3; c++) begin
      drive(NOP, 1'b1, 1'b0);
      check($sformatf("drain%0d_stall", c), stall_fd, 1);
      check($sformatf("drain%0d_bubble", c), bubble_x, 1);
      check($sformatf("drain%0d_halt", c), halted, 0);
    end
    drive(add(5'd1, 5'd2, 5'd3), 1'b1, 1'b1);
    check("halt_on", halted, 1);
    check("halt_stall", stall_fd, 1);
    check("halt_flush", flush_fd, 0);
    idle(3);
    check("halt_held", halted, 1);

    // Reset while draining returns everything to idle.
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(3);
    drive(ECALL, 1'b1, 1'b0);
    drive(NOP, 1'b0, 1'b0);
    drive(NOP, 1'b0, 1'b0);
    check("drain_before_rst", stall_fd, 1);
    reset = 1'b1;
    drive(NOP, 1'b0, 1'b0);
    check_quiet("rst_drain");
    reset = 1'b0;
    idle(6);
    check("post_rst_halt", halted, 0);
    check("post_rst_stall", stall_fd, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
